// File: rtl/cache_refill_pkg.sv
// Shared state encoding and width helpers for the cache block-refill broadcast responder.
package cache_refill_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_BCAST,
    S_DATA
  } state_t;

  function automatic int calc_baw(input int addr_in_width, input int block_width_bits);
    return addr_in_width - block_width_bits;
  endfunction

  function automatic int calc_ram_width(input int dwidth, input int block_width_bits);
    return dwidth * (2 ** block_width_bits);
  endfunction

  localparam int DEF_BAW       = calc_baw(16, 4);
  localparam int DEF_RAM_WIDTH = calc_ram_width(4, 4);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant plus index, searching from the pointer.
// Pointer moves to grant+1 (wrapping) only when the parent pulses en.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 en,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IW-1:0]        grant_idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            scan_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = (int'(ptr) + k) % NUM_PORTS;
      if (!found && req[scan_idx]) begin
        found     = 1'b1;
        grant_idx = IW'(scan_idx);
      end
    end
    grant[grant_idx] = found;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (grant_idx == IW'(NUM_PORTS - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/cache_refill_broadcast_responder.sv
// Arbitrates cache block misses, reads the block from memory, broadcasts it and acks all matching requesters.
// Min 5 cycles grant-to-grant; stalls in S_MEM_REQ while mem_req_ready is low. CACHE_REFILL_PERF_EN adds counters.
module cache_refill_broadcast_responder
  import cache_refill_pkg::*;
#(
  parameter int NUM_PORTS        = 4,
  parameter int DWIDTH           = 4,
  parameter int BLOCK_WIDTH_BITS = 4,
  parameter int ADDR_IN_WIDTH    = 16,
  localparam int BAW       = calc_baw(ADDR_IN_WIDTH, BLOCK_WIDTH_BITS),
  localparam int RAM_WIDTH = calc_ram_width(DWIDTH, BLOCK_WIDTH_BITS),
  localparam int IW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef CACHE_REFILL_PERF_EN
  output logic [31:0]              refill_count,
  output logic [31:0]              coalesced_count,
`endif
  input  logic [NUM_PORTS-1:0]     req_valid,
  input  logic [NUM_PORTS*BAW-1:0] req_addr,
  output logic [NUM_PORTS-1:0]     req_ready,
  output logic                     bcast_valid,
  output logic [BAW-1:0]           bcast_addr,
  output logic [RAM_WIDTH-1:0]     bcast_data,
  output logic                     mem_req_valid,
  output logic [BAW-1:0]           mem_req_addr,
  input  logic                     mem_req_ready,
  input  logic                     mem_rsp_valid,
  input  logic [RAM_WIDTH-1:0]     mem_rsp_data
);

  state_t               state;
  logic [BAW-1:0]       addr_q;
  logic [IW-1:0]        grant_q;
  logic [NUM_PORTS-1:0] arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_en;
  logic [BAW-1:0]       sel_addr;
  logic [BAW-1:0]       grant_addr;

  assign arb_en = (state == S_IDLE) && (|arb_grant);

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Every port still asking for the broadcast block is acked in the same cycle.
  always_comb begin
    sel_addr   = '0;
    grant_addr = '0;
    req_ready  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_grant[i]) sel_addr = req_addr[i*BAW +: BAW];
      if (IW'(i) == grant_q) grant_addr = req_addr[i*BAW +: BAW];
      req_ready[i] = (state == S_BCAST) && req_valid[i] && (req_addr[i*BAW +: BAW] == addr_q);
    end
  end

  assign bcast_valid   = (state == S_BCAST);
  assign bcast_addr    = addr_q;
  assign mem_req_valid = (state == S_MEM_REQ);
  assign mem_req_addr  = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      grant_q    <= '0;
      bcast_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_en) begin
            addr_q  <= sel_addr;
            grant_q <= arb_idx;
            state   <= S_MEM_REQ;
          end
        end
        S_MEM_REQ:  if (mem_req_ready) state <= S_MEM_WAIT;
        S_MEM_WAIT: begin
          if (mem_rsp_valid) begin
            bcast_data <= mem_rsp_data;
            state      <= S_BCAST;
          end
        end
        S_BCAST: state <= S_DATA;
        default: state <= S_IDLE;
      endcase
    end
  end

  // A granted port that still holds its original block must be among the acked ports.
  assert property (@(posedge clk) disable iff (rst)
    (state == S_BCAST && req_valid[grant_q] && grant_addr == addr_q) |-> req_ready[grant_q]);

`ifdef CACHE_REFILL_PERF_EN
  logic [31:0] ready_pop;

  always_comb begin
    ready_pop = '0;
    for (int i = 0; i < NUM_PORTS; i++) ready_pop = ready_pop + 32'(req_ready[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      refill_count    <= '0;
      coalesced_count <= '0;
    end else if (state == S_BCAST) begin
      refill_count <= refill_count + 32'd1;
      if (ready_pop != 32'd0) coalesced_count <= coalesced_count + ready_pop - 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_refill_broadcast_responder.sv
// Directed, table-driven bench for cache_refill_broadcast_responder (4 ports, 12-bit block address, 64-bit block).
module tb_cache_refill_broadcast_responder;

  localparam int NP  = 4;
  localparam int BAW = 12;
  localparam int RW  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req_valid;
  logic [NP*BAW-1:0] req_addr;
  logic [NP-1:0]     req_ready;
  logic              bcast_valid;
  logic [BAW-1:0]    bcast_addr;
  logic [RW-1:0]     bcast_data;
  logic              mem_req_valid;
  logic [BAW-1:0]    mem_req_addr;
  logic              mem_req_ready;
  logic              mem_rsp_valid;
  logic [RW-1:0]     mem_rsp_data;
`ifdef CACHE_REFILL_PERF_EN
  logic [31:0]       refill_count;
  logic [31:0]       coalesced_count;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cache_refill_broadcast_responder dut (
    .clk             (clk),
    .rst             (rst),
`ifdef CACHE_REFILL_PERF_EN
    .refill_count    (refill_count),
    .coalesced_count (coalesced_count),
`endif
    .req_valid       (req_valid),
    .req_addr        (req_addr),
    .req_ready       (req_ready),
    .bcast_valid     (bcast_valid),
    .bcast_addr      (bcast_addr),
    .bcast_data      (bcast_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_addr    (mem_req_addr),
    .mem_req_ready   (mem_req_ready),
    .mem_rsp_valid   (mem_rsp_valid),
    .mem_rsp_data    (mem_rsp_data)
  );

  typedef struct {
    logic [NP-1:0]     v;
    logic [NP*BAW-1:0] a;
    logic [RW-1:0]     d;
    int                lat;
    logic [BAW-1:0]    exp_addr;
    logic [NP-1:0]     exp_rdy;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [NP*BAW-1:0] pack4(input logic [BAW-1:0] a0, input logic [BAW-1:0] a1,
                                              input logic [BAW-1:0] a2, input logic [BAW-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (mem_req_valid === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL mem_req_timeout: got no mem_req_valid expected one within 20 cycles");
    end
  endtask

  // One full refill; bp = cycles of held-off mem_req_ready, drop = ports that release after acceptance.
  task automatic run_txn(input logic [NP-1:0] v, input logic [NP*BAW-1:0] a, input logic [RW-1:0] d,
                         input int lat, input logic [BAW-1:0] ea, input logic [NP-1:0] er,
                         input int bp, input logic [NP-1:0] drop);
    bit ok;
    step();
    req_valid = v;
    req_addr  = a;
    wait_mem_req(ok);
    if (ok) begin
      check("mem_req_addr", RW'(mem_req_addr), RW'(ea));
      for (int k = 0; k < bp; k++) begin
        @(negedge clk);
        check("bp_mem_req_valid", RW'(mem_req_valid), RW'(1));
        check("bp_mem_req_addr", RW'(mem_req_addr), RW'(ea));
        check("bp_no_bcast", RW'(bcast_valid), RW'(0));
      end
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      req_valid = req_valid & ~drop;
      repeat (lat) step();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = d;
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      @(negedge clk);
      check("bcast_valid", RW'(bcast_valid), RW'(1));
      check("bcast_addr", RW'(bcast_addr), RW'(ea));
      check("req_ready", RW'(req_ready), RW'(er));
      @(negedge clk);
      check("data_cycle_bcast_valid", RW'(bcast_valid), RW'(0));
      check("data_cycle_req_ready", RW'(req_ready), RW'(0));
      check("bcast_data", bcast_data, d);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;

    vecs[0] = '{4'b0100, pack4(12'h000, 12'h000, 12'h0A5, 12'h000), 64'hDEAD_BEEF_CAFE_0001, 2, 12'h0A5, 4'b0100};
    vecs[1] = '{4'b1011, pack4(12'h010, 12'h010, 12'h010, 12'h010), 64'h1111_2222_3333_4444, 1, 12'h010, 4'b1011};
    vecs[2] = '{4'b1111, pack4(12'h100, 12'h101, 12'h102, 12'h103), 64'h0000_0000_0000_0100, 0, 12'h100, 4'b0001};
    vecs[3] = '{4'b1111, pack4(12'h100, 12'h101, 12'h102, 12'h103), 64'h0000_0000_0000_0101, 3, 12'h101, 4'b0010};
    vecs[4] = '{4'b1111, pack4(12'h100, 12'h101, 12'h102, 12'h103), 64'h0000_0000_0000_0102, 1, 12'h102, 4'b0100};
    vecs[5] = '{4'b1111, pack4(12'h100, 12'h101, 12'h102, 12'h103), 64'h0000_0000_0000_0103, 0, 12'h103, 4'b1000};
    vecs[6] = '{4'b1111, pack4(12'h100, 12'h101, 12'h102, 12'h103), 64'hFFFF_FFFF_FFFF_FFFF, 2, 12'h100, 4'b0001};
    vecs[7] = '{4'b1001, pack4(12'h7FF, 12'h000, 12'h000, 12'hFFF), 64'hA5A5_5A5A_A5A5_5A5A, 1, 12'hFFF, 4'b1000};
    vecs[8] = '{4'b0111, pack4(12'h001, 12'h000, 12'h000, 12'h000), 64'h0123_4567_89AB_CDEF, 0, 12'h001, 4'b0001};

    repeat (2) step();
    @(negedge clk);
    check("rst_bcast_valid", RW'(bcast_valid), RW'(0));
    check("rst_req_ready", RW'(req_ready), RW'(0));
    check("rst_mem_req_valid", RW'(mem_req_valid), RW'(0));
    check("rst_bcast_addr", RW'(bcast_addr), RW'(0));
    check("rst_bcast_data", bcast_data, RW'(0));
`ifdef CACHE_REFILL_PERF_EN
    check("rst_refill_count", RW'(refill_count), RW'(0));
    check("rst_coalesced_count", RW'(coalesced_count), RW'(0));
`endif
    step();
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].lat, vecs[i].exp_addr, vecs[i].exp_rdy, 0, '0);
`ifdef CACHE_REFILL_PERF_EN
      if (i == 1) begin
        check("refill_count", RW'(refill_count), RW'(2));
        check("coalesced_count", RW'(coalesced_count), RW'(2));
      end
`endif
    end

    // Backpressure: pointer sits at 1, port 1 waits five cycles for mem_req_ready.
    run_txn(4'b0010, pack4(12'h000, 12'h222, 12'h000, 12'h000), 64'h2222_0000_2222_0000, 2,
            12'h222, 4'b0010, 5, '0);

    // Granted port 2 drops out; port 0 asking for the same block is still acked.
    run_txn(4'b0101, pack4(12'h333, 12'h000, 12'h333, 12'h000), 64'h3333_3333_3333_3333, 1,
            12'h333, 4'b0001, 0, 4'b0100);

    // Reset while waiting on memory: the late response must be ignored.
    begin
      bit ok;
      step();
      req_valid = 4'b0001;
      req_addr  = pack4(12'h444, 12'h000, 12'h000, 12'h000);
      wait_mem_req(ok);
      if (ok) check("rstmid_mem_req_addr", RW'(mem_req_addr), RW'(12'h444));
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      rst = 1'b1;
      req_valid = '0;
      step();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h4444_4444_4444_4444;
      step();
      mem_rsp_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_bcast_valid", RW'(bcast_valid), RW'(0));
      check("rstmid_req_ready", RW'(req_ready), RW'(0));
      check("rstmid_mem_req_valid", RW'(mem_req_valid), RW'(0));
      check("rstmid_bcast_addr", RW'(bcast_addr), RW'(0));
      check("rstmid_bcast_data", bcast_data, RW'(0));
      step();
      mem_rsp_valid = 1'b1;
      step();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      @(negedge clk);
      check("idle_rsp_bcast_valid", RW'(bcast_valid), RW'(0));
      check("idle_rsp_bcast_data", bcast_data, RW'(0));
`ifdef CACHE_REFILL_PERF_EN
      check("rstmid_refill_count", RW'(refill_count), RW'(0));
`endif
    end

    // Pointer must be back at 0: port 0 wins over port 2.
    run_txn(4'b0101, pack4(12'h555, 12'h000, 12'h556, 12'h000), 64'h5555_6666_7777_8888, 1,
            12'h555, 4'b0001, 0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cache_refill_broadcast_responder.md
Name: cache_refill_broadcast_responder

Overview:
Memory-side responder for the block-refill protocol issued by the directly mapped broadcast caches. It accepts block-address miss requests from NUM_PORTS caches and picks one with a round-robin arbiter. It fetches the block from backing memory, then broadcasts the block address and data to every cache. All ports currently requesting the same block are acknowledged in that single broadcast (coalescing).

Parameters:
NUM_PORTS, 4, number of requesting caches
DWIDTH, 4, bits per word
BLOCK_WIDTH_BITS, 4, log2 words per block
ADDR_IN_WIDTH, 16, cache-side word address width; block address width BAW = ADDR_IN_WIDTH-BLOCK_WIDTH_BITS
(derived) RAM_WIDTH = DWIDTH*2**BLOCK_WIDTH_BITS

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_PORTS  per-port miss request (cache addr_out_valid)
req_addr  in  NUM_PORTS*BAW  packed block addresses, port i at [i*BAW+:BAW]
req_ready  out  NUM_PORTS  per-port acknowledge (cache addr_out_ready)
bcast_valid  out  1  broadcast strobe (cache addr_broadcast_valid)
bcast_addr  out  BAW  broadcast block address
bcast_data  out  RAM_WIDTH  block data (cache data_in)
mem_req_valid  out  1  backing-memory read request
mem_req_addr  out  BAW  backing-memory block address
mem_req_ready  in  1  backing memory accepts request
mem_rsp_valid  in  1  read data valid, one-cycle pulse
mem_rsp_data  in  RAM_WIDTH  read data

Behaviour:
- Reset: state S_IDLE, rr pointer 0, req_ready=0, bcast_valid=0, mem_req_valid=0, bcast_addr=0, bcast_data=0, addr_q=0, grant_q=0.
- Reset mid-operation: abandon the transaction and return to S_IDLE. Any mem_rsp_valid arriving outside S_MEM_WAIT is ignored.
- S_IDLE:
  - If any req_valid, grant the first valid port at or after the rr pointer (wrapping), latch addr_q and grant_q, set pointer=(grant+1) mod NUM_PORTS, go to S_MEM_REQ.
  - Otherwise stay.
- S_MEM_REQ: mem_req_valid=1, mem_req_addr=addr_q. On mem_req_ready go to S_MEM_WAIT.
- S_MEM_WAIT: on mem_rsp_valid, register bcast_data<=mem_rsp_data and go to S_BCAST. mem_rsp_valid in the same cycle as acceptance is not possible; memory latency is at least 1 cycle.
- S_BCAST, exactly one cycle:
  - bcast_valid=1, bcast_addr=addr_q.
  - req_ready[i]=req_valid[i] && req_addr[i]==addr_q, for all i.
  - If the granted port has dropped req_valid, the broadcast still occurs.
  - Go to S_DATA.
- S_DATA, one cycle: no outputs asserted. bcast_data stays stable, as caches capture it here. Go to S_IDLE.
- bcast_data changes only on mem_rsp capture, so it is stable from S_BCAST+1 until the next S_MEM_WAIT capture.
- req_ready and bcast_valid are combinational from state. They are never asserted outside S_BCAST, and req_ready is never asserted for a non-valid port.
- Minimum latency: request seen in S_IDLE at cycle 0, mem_req_valid at cycle 1, rsp at cycle 2, bcast at cycle 3, data cycle 4, next grant possible at cycle 5.
- Fairness: with all ports continuously requesting different blocks, grants rotate 0,1,2,3,0...

Optional Feature:
CACHE_REFILL_PERF_EN
- With the macro: adds outputs refill_count[31:0] and coalesced_count[31:0]. Both reset to 0.
- refill_count increments once per S_BCAST.
- coalesced_count increments by (popcount(req_ready)-1) when popcount>=1.
- Both counters wrap at 2^32.
- Without the macro: the ports and logic are absent.

Decomposition:
- Package cache_refill_pkg holds:
  - state typedef enum logic[2:0] {S_IDLE,S_MEM_REQ,S_MEM_WAIT,S_BCAST,S_DATA};
  - width helper localparams for BAW and RAM_WIDTH.
- Sub-module rr_arbiter: NUM_PORTS request vector in, one-hot grant plus index out. The pointer advances only on an enable pulse from the parent.

Test Plan:
- Single request: port 2 req_addr=0x0A5, memory returns 0xDEAD... after 3 cycles -> mem_req_addr=0x0A5; one-cycle bcast_valid with bcast_addr=0x0A5; req_ready=4'b0100; bcast_data equals the data on the following cycle.
- Coalescing: ports 0,1,3 all request 0x010 -> one memory read; req_ready=4'b1011 in a single cycle; refill_count=1, coalesced_count=2 (with PERF_EN).
- Round-robin: all ports request distinct addresses 0x100..0x103 and hold -> grants in order 0,1,2,3 then 0; each port is acknowledged exactly once per rotation.
- Backpressure: hold mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_req_addr stay stable; no bcast_valid until the response arrives.
- Reset mid-operation: assert rst in S_MEM_WAIT, then pulse mem_rsp_valid -> outputs return to reset values; no bcast_valid; a later request is served normally starting from pointer 0.
- Dropped requester: granted port deasserts req_valid before the response -> bcast_valid still pulses with the correct address; req_ready=0 for that port.
